// File: rtl/tx_mon_pkg.sv
// Shared constants for the clktx-side packet monitor: data types, error bit
// positions and FSM encoding.
package tx_mon_pkg;

    localparam logic [5:0] DtVss    = 6'h01;
    localparam logic [5:0] DtVse    = 6'h11;
    localparam logic [5:0] DtHss    = 6'h21;
    localparam logic [5:0] DtRgb888 = 6'h3e;

    localparam int unsigned NumLongDt = 4;
    localparam logic [6*NumLongDt-1:0] LongDtList = {6'h3e, 6'h29, 6'h39, 6'h19};

    localparam int unsigned ErrLines      = 0;
    localparam int unsigned ErrWords      = 1;
    localparam int unsigned ErrBytes      = 2;
    localparam int unsigned ErrOverlap    = 3;
    localparam int unsigned ErrStray      = 4;
    localparam int unsigned ErrVssInFrame = 5;
    localparam int unsigned ErrTimeout    = 6;
    localparam int unsigned ErrNoVss      = 7;

    typedef enum logic [1:0] {
        StSeek,
        StFrame,
        StPayload
    } state_e;

    function automatic logic is_long_dt(input logic [5:0] dt);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumLongDt; i++) begin
            if (dt == LongDtList[i*6 +: 6]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/tx_payload_checker.sv
// Payload word counter, expected-length compare and inter-word stall timeout
// for the packet currently in its payload phase.
module tx_payload_checker #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clktx,
    input  logic        rstn,
    input  logic        clr,
    input  logic        start,
    input  logic        active,
    input  logic        payload_en,
    input  logic        payload_en_last,
    input  logic [16:0] exp_words,
    output logic        payload_done,
    output logic        len_err,
    output logic        timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [16:0]   exp_q, exp_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [16:0]   words_now;

    always_comb begin
        payload_done = active & payload_en & payload_en_last;
        timeout      = active & ~payload_en & (tmo_q == TimeoutVal);
        // The closing word itself counts toward the total.
        words_now    = {1'b0, word_cnt_q} + {16'd0, payload_en};
        len_err      = payload_done & (words_now != exp_q);

        exp_d      = exp_q;
        word_cnt_d = word_cnt_q;
        tmo_d      = tmo_q;
        if (active & payload_en) begin
            if (word_cnt_q != 16'hffff) word_cnt_d = word_cnt_q + 16'd1;
            tmo_d = '0;
        end else if (active & (tmo_q != TimeoutVal)) begin
            tmo_d = tmo_q + 1'b1;
        end
        if (payload_done | timeout | ~active) begin
            word_cnt_d = '0;
            tmo_d      = '0;
        end
        if (start) begin
            word_cnt_d = '0;
            tmo_d      = '0;
            exp_d      = exp_words;
        end
        if (clr) begin
            word_cnt_d = '0;
            tmo_d      = '0;
            exp_d      = '0;
        end
    end

    always_ff @(posedge clktx or negedge rstn) begin
        if (!rstn) begin
            word_cnt_q <= '0;
            exp_q      <= '0;
            tmo_q      <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            exp_q      <= exp_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule

// File: rtl/tx_packet_monitor.sv
// Passive frame-structure checker on the bridge-to-TX-host command/payload
// stream; publishes per-frame statistics and sticky error flags.
module tx_packet_monitor
    import tx_mon_pkg::*;
#(
    parameter int unsigned EXP_LINES      = 1920,
    parameter int unsigned EXP_BYTES      = 3240,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clktx,
    input  logic        rstn,
    input  logic        clr,
    input  logic        req,
    input  logic        ack,
    input  logic [1:0]  cmd_vc,
    input  logic [5:0]  cmd_data_type,
    input  logic [15:0] cmd_byte_count,
    input  logic        payload_en,
    input  logic        payload_en_last,
    output logic        in_frame,
    output logic        frame_done,
    output logic [15:0] line_count,
    output logic [15:0] hsync_count,
    output logic [15:0] frame_count,
    output logic [7:0]  err_flags,
    output logic        err_any
);

    state_e      state_q, state_d, ret_q, ret_d, base;
    logic [15:0] line_q, line_d, hsync_q, hsync_d;
    logic [15:0] line_count_q, line_count_d, hsync_count_q, hsync_count_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  err_q, err_d;
    logic        frame_done_q, frame_done_d;
    logic        pend_vld_q, pend_vld_d;
    logic [5:0]  pend_dt_q, pend_dt_d, cmd_dt;
    logic [15:0] pend_bc_q, pend_bc_d, cmd_bc;
    logic        acc, cmd_vld, start, pl_done, len_err, tmo;
    logic [16:0] exp_words;
    logic        unused_vc;

    assign unused_vc = ^cmd_vc;
    assign acc       = req & ack;

    tx_payload_checker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_payload_checker (
        .clktx          (clktx),
        .rstn           (rstn),
        .clr            (clr),
        .start          (start),
        .active         (state_q == StPayload),
        .payload_en     (payload_en),
        .payload_en_last(payload_en_last),
        .exp_words      (exp_words),
        .payload_done   (pl_done),
        .len_err        (len_err),
        .timeout        (tmo)
    );

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        line_d        = line_q;
        hsync_d       = hsync_q;
        line_count_d  = line_count_q;
        hsync_count_d = hsync_count_q;
        frame_count_d = frame_count_q;
        err_d         = err_q;
        frame_done_d  = 1'b0;
        pend_vld_d    = pend_vld_q;
        pend_dt_d     = pend_dt_q;
        pend_bc_d     = pend_bc_q;
        start         = 1'b0;
        base          = state_q;
        cmd_vld       = acc;
        cmd_dt        = cmd_data_type;
        cmd_bc        = cmd_byte_count;

        if (payload_en && (state_q != StPayload)) err_d[ErrStray] = 1'b1;

        if (state_q == StPayload) begin
            cmd_vld = 1'b0;
            if (acc && !pl_done) err_d[ErrOverlap] = 1'b1;
            if (pl_done || tmo) begin
                // Close the payload, then run any command from the return state.
                if (len_err) err_d[ErrWords] = 1'b1;
                if (tmo) err_d[ErrTimeout] = 1'b1;
                base       = ret_q;
                state_d    = ret_q;
                pend_vld_d = 1'b0;
                if (acc) begin
                    cmd_vld = 1'b1;
                end else if (pend_vld_q) begin
                    cmd_vld = 1'b1;
                    cmd_dt  = pend_dt_q;
                    cmd_bc  = pend_bc_q;
                end
            end else if (acc) begin
                pend_vld_d = 1'b1;
                pend_dt_d  = cmd_data_type;
                pend_bc_d  = cmd_byte_count;
            end
        end

        exp_words = ({1'b0, cmd_bc} + 17'd3) >> 2;

        if (cmd_vld) begin
            case (base)
                StSeek: begin
                    if (cmd_dt == DtVss) begin
                        state_d = StFrame;
                        line_d  = '0;
                        hsync_d = '0;
                    end else if (cmd_dt == DtRgb888) begin
                        err_d[ErrNoVss] = 1'b1;
                    end else if (is_long_dt(cmd_dt)) begin
                        state_d = StPayload;
                        ret_d   = StSeek;
                        start   = 1'b1;
                    end
                end
                StFrame: begin
                    if (cmd_dt == DtHss) begin
                        hsync_d = hsync_q + 16'd1;
                    end else if (cmd_dt == DtVse) begin
                        state_d       = StSeek;
                        line_count_d  = line_q;
                        hsync_count_d = hsync_q;
                        frame_count_d = frame_count_q + 16'd1;
                        frame_done_d  = 1'b1;
                        if (line_q != 16'(EXP_LINES)) err_d[ErrLines] = 1'b1;
                    end else if (cmd_dt == DtVss) begin
                        err_d[ErrVssInFrame] = 1'b1;
                        line_d  = '0;
                        hsync_d = '0;
                    end else if (is_long_dt(cmd_dt)) begin
                        state_d = StPayload;
                        ret_d   = StFrame;
                        start   = 1'b1;
                        if (cmd_dt == DtRgb888) begin
                            line_d = line_q + 16'd1;
                            if (cmd_bc != 16'(EXP_BYTES)) err_d[ErrBytes] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clr) begin
            state_d       = StSeek;
            ret_d         = StSeek;
            line_d        = '0;
            hsync_d       = '0;
            line_count_d  = '0;
            hsync_count_d = '0;
            frame_count_d = '0;
            err_d         = '0;
            frame_done_d  = 1'b0;
            pend_vld_d    = 1'b0;
            pend_dt_d     = '0;
            pend_bc_d     = '0;
        end
    end

    always_ff @(posedge clktx or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StSeek;
            ret_q         <= StSeek;
            line_q        <= '0;
            hsync_q       <= '0;
            line_count_q  <= '0;
            hsync_count_q <= '0;
            frame_count_q <= '0;
            err_q         <= '0;
            frame_done_q  <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_dt_q     <= '0;
            pend_bc_q     <= '0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            line_q        <= line_d;
            hsync_q       <= hsync_d;
            line_count_q  <= line_count_d;
            hsync_count_q <= hsync_count_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
            frame_done_q  <= frame_done_d;
            pend_vld_q    <= pend_vld_d;
            pend_dt_q     <= pend_dt_d;
            pend_bc_q     <= pend_bc_d;
        end
    end

    assign in_frame    = (state_q == StFrame) || ((state_q == StPayload) && (ret_q == StFrame));
    assign frame_done  = frame_done_q;
    assign line_count  = line_count_q;
    assign hsync_count = hsync_count_q;
    assign frame_count = frame_count_q;
    assign err_flags   = err_q;
    assign err_any     = |err_q;

endmodule

// File: tb/tb_tx_packet_monitor.sv
// Directed bench for tx_packet_monitor: a per-cycle vector table plus
// hand-written frame, overlap, timeout and reset sequences.
module tb_tx_packet_monitor;

    localparam int unsigned ExpLines = 4;
    localparam int unsigned ExpBytes = 3240;
    localparam int unsigned NumVec   = 18;

    logic        clktx = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        req = 1'b0;
    logic        ack = 1'b0;
    logic [1:0]  cmd_vc = 2'd0;
    logic [5:0]  cmd_data_type = 6'd0;
    logic [15:0] cmd_byte_count = 16'd0;
    logic        payload_en = 1'b0;
    logic        payload_en_last = 1'b0;
    logic        in_frame, frame_done, err_any;
    logic [15:0] line_count, hsync_count, frame_count;
    logic [7:0]  err_flags;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    typedef struct {
        logic        clr, req, ack;
        logic [5:0]  dt;
        logic [15:0] bc;
        logic        pen, last;
        logic        in_frame, done;
        logic [7:0]  err;
        logic [15:0] fc;
    } vec_t;

    vec_t vt[NumVec];

    tx_packet_monitor #(
        .EXP_LINES     (ExpLines),
        .EXP_BYTES     (ExpBytes),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .clktx          (clktx),
        .rstn           (rstn),
        .clr            (clr),
        .req            (req),
        .ack            (ack),
        .cmd_vc         (cmd_vc),
        .cmd_data_type  (cmd_data_type),
        .cmd_byte_count (cmd_byte_count),
        .payload_en     (payload_en),
        .payload_en_last(payload_en_last),
        .in_frame       (in_frame),
        .frame_done     (frame_done),
        .line_count     (line_count),
        .hsync_count    (hsync_count),
        .frame_count    (frame_count),
        .err_flags      (err_flags),
        .err_any        (err_any)
    );

    always #5 clktx = ~clktx;

    always @(negedge clktx) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    function automatic vec_t mk(input logic c, input logic r, input logic a, input logic [5:0] dt,
                                input logic [15:0] bc, input logic pen, input logic last,
                                input logic inf, input logic dn, input logic [7:0] err,
                                input logic [15:0] fc);
        vec_t v;
        v.clr = c; v.req = r; v.ack = a; v.dt = dt; v.bc = bc; v.pen = pen; v.last = last;
        v.in_frame = inf; v.done = dn; v.err = err; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        clr = 1'b0; req = 1'b0; ack = 1'b0; cmd_data_type = 6'd0; cmd_byte_count = 16'd0;
        payload_en = 1'b0; payload_en_last = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clktx);
        #1;
    endtask

    task automatic cmd(input logic [5:0] dt, input logic [15:0] bc);
        req = 1'b1; ack = 1'b1; cmd_data_type = dt; cmd_byte_count = bc;
        cmd_vc = dt[1:0];
        cyc();
        idle();
    endtask

    task automatic words(input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            payload_en = 1'b1;
            payload_en_last = last && (i == n - 1);
            cyc();
        end
        idle();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        idle();
    endtask

    task automatic line(input logic [15:0] bc, input int n);
        cmd(6'h21, 16'd0);
        cmd(6'h3e, bc);
        words(n, 1'b1);
    endtask

    initial begin
        int d0;
        vt[0]  = mk(1, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'h00, 0);
        vt[1]  = mk(0, 1, 0, 6'h01, 0, 0, 0, 0, 0, 8'h00, 0);
        vt[2]  = mk(0, 1, 1, 6'h01, 0, 0, 0, 1, 0, 8'h00, 0);
        vt[3]  = mk(0, 1, 1, 6'h21, 0, 0, 0, 1, 0, 8'h00, 0);
        vt[4]  = mk(0, 1, 1, 6'h29, 5, 0, 0, 1, 0, 8'h00, 0);
        vt[5]  = mk(0, 0, 0, 6'h00, 0, 1, 0, 1, 0, 8'h00, 0);
        vt[6]  = mk(0, 0, 0, 6'h00, 0, 1, 1, 1, 0, 8'h00, 0);
        vt[7]  = mk(0, 1, 1, 6'h29, 8, 0, 0, 1, 0, 8'h00, 0);
        vt[8]  = mk(0, 0, 0, 6'h00, 0, 1, 1, 1, 0, 8'h02, 0);
        vt[9]  = mk(0, 0, 0, 6'h00, 0, 1, 0, 1, 0, 8'h12, 0);
        vt[10] = mk(0, 0, 1, 6'h11, 0, 0, 0, 1, 0, 8'h12, 0);
        vt[11] = mk(0, 1, 1, 6'h01, 0, 0, 0, 1, 0, 8'h32, 0);
        vt[12] = mk(0, 1, 1, 6'h11, 0, 0, 0, 0, 1, 8'h33, 1);
        vt[13] = mk(0, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'h33, 1);
        vt[14] = mk(0, 1, 1, 6'h3e, 0, 0, 0, 0, 0, 8'hb3, 1);
        vt[15] = mk(0, 1, 1, 6'h19, 4, 0, 0, 0, 0, 8'hb3, 1);
        vt[16] = mk(0, 0, 0, 6'h00, 0, 1, 1, 0, 0, 8'hb3, 1);
        vt[17] = mk(1, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'h00, 0);

        // Reset state
        #12;
        chk("rst_in_frame", {31'd0, in_frame}, 0);
        chk("rst_err", {24'd0, err_flags}, 0);
        chk("rst_frame_count", {16'd0, frame_count}, 0);
        chk("rst_err_any", {31'd0, err_any}, 0);
        @(negedge clktx);
        rstn = 1'b1;

        // Vector table
        for (int i = 0; i < NumVec; i++) begin
            clr = vt[i].clr; req = vt[i].req; ack = vt[i].ack;
            cmd_data_type = vt[i].dt; cmd_byte_count = vt[i].bc;
            payload_en = vt[i].pen; payload_en_last = vt[i].last;
            cyc();
            chk($sformatf("vec%0d_in_frame", i), {31'd0, in_frame}, {31'd0, vt[i].in_frame});
            chk($sformatf("vec%0d_done", i), {31'd0, frame_done}, {31'd0, vt[i].done});
            chk($sformatf("vec%0d_err", i), {24'd0, err_flags}, {24'd0, vt[i].err});
            chk($sformatf("vec%0d_fc", i), {16'd0, frame_count}, {16'd0, vt[i].fc});
        end
        idle();

        // Clean frame
        d0 = done_cnt;
        cmd(6'h01, 0);
        for (int l = 0; l < ExpLines; l++) line(16'd3240, 810);
        chk("clean_done_low_before_vse", {31'd0, frame_done}, 0);
        chk("clean_count_held", {16'd0, line_count}, 0);
        cmd(6'h11, 0);
        chk("clean_done", {31'd0, frame_done}, 1);
        chk("clean_lines", {16'd0, line_count}, ExpLines);
        chk("clean_hsync", {16'd0, hsync_count}, ExpLines);
        chk("clean_fc", {16'd0, frame_count}, 1);
        chk("clean_err", {24'd0, err_flags}, 0);
        chk("clean_in_frame", {31'd0, in_frame}, 0);
        cyc(); cyc();
        chk("clean_done_pulses", done_cnt - d0, 1);

        // Async reset mid-frame
        cmd(6'h01, 0);
        cmd(6'h3e, 16'd3240);
        words(400, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("rstn_in_frame", {31'd0, in_frame}, 0);
        chk("rstn_fc", {16'd0, frame_count}, 0);
        chk("rstn_lines", {16'd0, line_count}, 0);
        @(negedge clktx);
        rstn = 1'b1;
        words(410, 1'b1);
        chk("rstn_stray_err", {24'd0, err_flags}, 8'h10);

        // Short frame
        do_clr();
        d0 = done_cnt;
        cmd(6'h01, 0);
        for (int l = 0; l < ExpLines - 1; l++) line(16'd3240, 810);
        cmd(6'h11, 0);
        cyc();
        chk("short_err", {24'd0, err_flags}, 8'h01);
        chk("short_lines", {16'd0, line_count}, ExpLines - 1);
        chk("short_done_pulses", done_cnt - d0, 1);
        chk("short_err_any", {31'd0, err_any}, 1);

        // clr at word 400 of a payload
        cmd(6'h01, 0);
        cmd(6'h3e, 16'd3240);
        words(399, 1'b0);
        clr = 1'b1; payload_en = 1'b1;
        cyc();
        idle();
        chk("clr_err", {24'd0, err_flags}, 0);
        chk("clr_fc", {16'd0, frame_count}, 0);
        chk("clr_lines", {16'd0, line_count}, 0);
        chk("clr_in_frame", {31'd0, in_frame}, 0);
        words(410, 1'b1);
        chk("clr_stray_err", {24'd0, err_flags}, 8'h10);

        // Word count mismatch, then byte count mismatch
        do_clr();
        cmd(6'h01, 0);
        line(16'd3240, 809);
        chk("short_payload_err", {24'd0, err_flags}, 8'h02);
        do_clr();
        cmd(6'h01, 0);
        line(16'd3236, 809);
        chk("byte_count_err", {24'd0, err_flags}, 8'h04);

        // Command one cycle before the last word
        do_clr();
        cmd(6'h01, 0);
        cmd(6'h3e, 16'd3240);
        words(808, 1'b0);
        req = 1'b1; ack = 1'b1; cmd_data_type = 6'h21; payload_en = 1'b1;
        cyc();
        idle();
        chk("overlap_err", {24'd0, err_flags}, 8'h08);
        chk("overlap_in_frame", {31'd0, in_frame}, 1);
        words(1, 1'b1);
        chk("overlap_close_err", {24'd0, err_flags}, 8'h08);
        cmd(6'h11, 0);
        chk("overlap_hsync", {16'd0, hsync_count}, 1);
        chk("overlap_final_err", {24'd0, err_flags}, 8'h09);

        // Command in the same cycle as the last word
        do_clr();
        cmd(6'h01, 0);
        cmd(6'h3e, 16'd3240);
        words(809, 1'b0);
        req = 1'b1; ack = 1'b1; cmd_data_type = 6'h21;
        payload_en = 1'b1; payload_en_last = 1'b1;
        cyc();
        idle();
        chk("simul_err", {24'd0, err_flags}, 0);
        cmd(6'h11, 0);
        chk("simul_hsync", {16'd0, hsync_count}, 1);
        chk("simul_lines", {16'd0, line_count}, 1);
        chk("simul_final_err", {24'd0, err_flags}, 8'h01);

        // Payload stall timeout
        do_clr();
        cmd(6'h01, 0);
        cmd(6'h3e, 16'd3240);
        repeat (4096) cyc();
        chk("tmo_not_yet", {24'd0, err_flags}, 0);
        cyc();
        chk("tmo_err", {24'd0, err_flags}, 8'h40);
        chk("tmo_in_frame", {31'd0, in_frame}, 1);
        cmd(6'h21, 0);
        cmd(6'h11, 0);
        chk("tmo_back_in_frame", {24'd0, err_flags}, 8'h41);
        chk("tmo_hsync", {16'd0, hsync_count}, 1);

        // Stray payload word in SEEK
        do_clr();
        words(1, 1'b0);
        chk("seek_stray_err", {24'd0, err_flags}, 8'h10);
        chk("seek_stray_in_frame", {31'd0, in_frame}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
